lut_table_dumper: RTL
=====================

LUT_TABLE_DUMPER -- requirements
Module: lut_table_dumper

Interface
REQ-001 Parameter: IN_BITS, default 8, neuron input width; the sweep covers 2^IN_BITS codes.
REQ-002 Parameter: OUT_BITS, default 1, neuron output width.
REQ-003 Parameter: WORD_W, default 8, streamed word width; (2^IN_BITS*OUT_BITS) SHALL be a multiple of WORD_W.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-006 Port: start  in  1  single-cycle request to begin a sweep; ignored unless the block is idle.
REQ-007 Port: busy  out  1  high from the cycle after an accepted start until the done pulse.
REQ-008 Port: done  out  1  single-cycle pulse after the last word is accepted.
REQ-009 Port: lut_addr  out  IN_BITS  registered input code driven to the combinational neuron under test.
REQ-010 Port: lut_data  in  OUT_BITS  neuron output for lut_addr, valid in the same cycle.
REQ-011 Port: out_valid  out  1  output word valid.
REQ-012 Port: out_ready  in  1  downstream accept.
REQ-013 Port: out_data  out  WORD_W  packed truth-table word.
REQ-014 Port: out_idx  out  IN_BITS  word index, 0 for the first word, incrementing by 1.

Function
REQ-015 States: IDLE, SWEEP, DRAIN, DONE; the block SHALL leave IDLE only on start.
REQ-016 IDLE+start: go to SWEEP; lut_addr=0, pack buffer cleared, word index=0.
REQ-017 SWEEP: at each rising edge where the block is not stalled, sample lut_data into the pack buffer and increment lut_addr by 1.
REQ-018 Packing: OUT_BITS-wide field j of a word holds lut_data for address (word_index*WORD_W/OUT_BITS + j); field 0 occupies the LSBs.
REQ-019 When a word completes, it SHALL be loaded into the output register with out_valid=1 on the next cycle.
REQ-020 Stall: if a completed word is pending while out_valid=1 and out_ready=0, lut_addr SHALL hold and no sample SHALL be taken until the handshake frees the register.
REQ-021 out_data and out_idx SHALL stay stable while out_valid=1 and out_ready=0; a transfer occurs on out_valid&&out_ready.
REQ-022 Simultaneous handshake and completion of a new word: the new word SHALL be loaded in the same edge, with no bubble.
REQ-023 Sampling the address 2^IN_BITS-1 SHALL move the block to DRAIN; lut_addr wraps to 0 and holds there.
REQ-024 DRAIN: wait for acceptance of the final word, then DONE (done=1 for one cycle), then IDLE.
REQ-025 Throughput: with out_ready held at 1, a sweep SHALL take 2^IN_BITS+3 cycles from the start edge to the done pulse.
REQ-026 start while busy SHALL have no effect.

Reset
REQ-027 Assertion of rst_n=0 at any time, including mid-sweep, SHALL immediately force IDLE and clear: busy=0, done=0, out_valid=0, out_data=0, out_idx=0, lut_addr=0, pack buffer=0.
REQ-028 After deassertion, a partial sweep SHALL NOT resume; a new start is required.

Structure
REQ-029 State enum, default parameter values, and the word-count function SHALL reside in a shared package, lut_dump_pkg.
REQ-030 The pack-and-hold output stage SHALL be a sub-module, lut_dump_packer: a shift-in buffer plus a one-entry valid/ready register.
REQ-031 The neuron under test SHALL be external; lut_table_dumper SHALL contain no truth-table content.

Verification
REQ-032 lut_data=(lut_addr==8'hFF), out_ready=1, start pulse -> 32 words; words 0..30 = 0x00, word 31 = 0x80 with out_idx=31; done at cycle 259.
REQ-033 lut_data=lut_addr[0] -> every word = 0xAA.
REQ-034 lut_data=lut_addr[0], out_ready low for 10 cycles at word 3 -> lut_addr frozen, out_data/out_idx stable, no word lost or duplicated.
REQ-035 rst_n pulsed low at lut_addr=100 -> all outputs 0 asynchronously; a restart produces the full 32-word sequence from out_idx=0.
REQ-036 start re-pulsed while busy, and out_ready toggled randomly -> exactly one sweep; the output stream matches a reference model; one done pulse.

Source files
------------

// File: rtl/lut_dump_pkg.sv
// Shared definitions for the LUT truth-table dumper: sweep states,
// default geometry and the number of packed words per sweep.
package lut_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

    localparam int DEF_IN_BITS  = 8;
    localparam int DEF_OUT_BITS = 1;
    localparam int DEF_WORD_W   = 8;

    // Number of WORD_W-wide words holding the full truth table.
    function automatic int word_count(input int in_bits, input int out_bits, input int word_w);
        return ((1 << in_bits) * out_bits) / word_w;
    endfunction

endpackage

// File: rtl/lut_dump_if.sv
// Valid/ready stream carrying packed truth-table words and their index.
interface lut_dump_if
    import lut_dump_pkg::*;
#(
    parameter int IN_BITS = DEF_IN_BITS,
    parameter int WORD_W  = DEF_WORD_W
) ();

    logic                out_valid;
    logic                out_ready;
    logic [WORD_W-1:0]   out_data;
    logic [IN_BITS-1:0]  out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );

endinterface

// File: rtl/lut_dump_packer.sv
// Pack-and-hold stage: samples are shifted into a word buffer (first sample
// ends up in the LSB field); a completed word moves into a one-entry
// valid/ready output register as soon as that register is free.
module lut_dump_packer
    import lut_dump_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int WORD_W   = DEF_WORD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                smp_en,
    input  logic [OUT_BITS-1:0] smp_data,
    input  logic                out_ready,
    output logic                pending,
    output logic                stall,
    output logic                out_valid,
    output logic [WORD_W-1:0]   out_data,
    output logic [IN_BITS-1:0]  out_idx
);

    localparam int FIELDS = WORD_W / OUT_BITS;
    localparam int CNT_W  = $clog2(FIELDS + 1);
    localparam int SHIFT  = WORD_W - OUT_BITS;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIELDS);

    logic [WORD_W-1:0]  buf_q,   buf_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               full_q,  full_d;
    logic               valid_q, valid_d;
    logic [WORD_W-1:0]  data_q,  data_d;
    logic [IN_BITS-1:0] idx_q,   idx_d;
    logic [IN_BITS-1:0] nidx_q,  nidx_d;
    logic               load;

    // A full buffer moves out whenever the output register is empty or
    // being drained this cycle; otherwise the sweep must stall.
    assign load      = full_q && (!valid_q || out_ready);
    assign stall     = full_q && valid_q && !out_ready;
    assign pending   = full_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;

    // Next-state for the shift buffer and the output register.
    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        cnt_inc = '0;
        full_d  = full_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        nidx_d  = nidx_q;
        if (clr) begin
            buf_d   = '0;
            cnt_d   = '0;
            full_d  = 1'b0;
            valid_d = 1'b0;
            data_d  = '0;
            idx_d   = '0;
            nidx_d  = '0;
        end else begin
            if (load) begin
                valid_d = 1'b1;
                data_d  = buf_q;
                idx_d   = nidx_q;
                nidx_d  = nidx_q + 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
                full_d  = 1'b0;
            end else if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
            // A sample may land in the same edge as a load, so it builds
            // on the already-emptied buffer (no bubble between words).
            if (smp_en) begin
                buf_d   = (buf_d >> OUT_BITS) | (WORD_W'(smp_data) << SHIFT);
                cnt_inc = cnt_d + 1'b1;
                if (cnt_inc == CNT_FULL) begin
                    full_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    // Buffer and output register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            nidx_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            nidx_q  <= nidx_d;
        end
    end

endmodule

// File: rtl/lut_table_dumper.sv
// Sweeps every input code of an external combinational neuron and streams
// its truth table out as packed words.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; lut_addr parked at 0
//   ST_SWEEP | driving lut_addr, sampling lut_data each unstalled cycle
//   ST_DRAIN | last code sampled; waiting for the final word to transfer
//   ST_DONE  | one-cycle done pulse, then back to idle
module lut_table_dumper
    import lut_dump_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS,
    parameter int WORD_W   = DEF_WORD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IN_BITS-1:0]  lut_addr,
    input  logic [OUT_BITS-1:0] lut_data,
    lut_dump_if.master          out_if
);

    localparam int N_WORDS = word_count(IN_BITS, OUT_BITS, WORD_W);
    localparam logic [IN_BITS-1:0] ADDR_MAX = '1;
    localparam logic [IN_BITS-1:0] LAST_IDX = IN_BITS'(N_WORDS - 1);

    dump_state_e        state_q, state_d;
    logic [IN_BITS-1:0] addr_q,  addr_d;
    logic               clr;
    logic               smp_en;
    logic               pending;
    logic               stall;

    assign lut_addr = addr_q;

    lut_dump_packer #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .WORD_W   (WORD_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .smp_en    (smp_en),
        .smp_data  (lut_data),
        .out_ready (out_if.out_ready),
        .pending   (pending),
        .stall     (stall),
        .out_valid (out_if.out_valid),
        .out_data  (out_if.out_data),
        .out_idx   (out_if.out_idx)
    );

    // Sweep sequencing: next state, address and control strobes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        clr     = 1'b0;
        smp_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    addr_d  = '0;
                    clr     = 1'b1;
                end
            end
            ST_SWEEP: begin
                busy = 1'b1;
                if (!stall) begin
                    smp_en = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == ADDR_MAX) begin
                        state_d = ST_DRAIN;
                        addr_d  = '0;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Finish only once the last word itself has been taken.
                if (!pending && out_if.out_valid && out_if.out_ready &&
                    (out_if.out_idx == LAST_IDX)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

endmodule
